// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the PC, the three pipeline valid bits and the
// RUN/HALTED/ERROR state, and counts retired instructions.
module pc_sequencer #(
    parameter int                PC_W        = 16,
    parameter logic [PC_W-1:0]   RESET_PC    = '0,
    parameter int                INSTR_BYTES = 2,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              if_flush,
    input  logic              id_flush,
    input  logic              ex_flush,
    input  logic              pc_op,
    input  logic              b_jmp,
    input  logic              overflow_error_warning,
    input  logic              stall,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [PC_W-1:0]   jump_target,
    output logic [PC_W-1:0]   pc,
    output logic              if_id_valid,
    output logic              id_ex_valid,
    output logic              ex_mem_valid,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_ERROR  = 2'b10
    } state_t;

    localparam logic [PC_W-1:0]  PC_INC  = PC_W'(INSTR_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_reg;
    logic [PC_W-1:0]    pc_reg;
    logic               if_id_valid_reg;
    logic               id_ex_valid_reg;
    logic               ex_mem_valid_reg;
    logic [CNT_W-1:0]   retired_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_RUN;
            pc_reg           <= RESET_PC;
            if_id_valid_reg  <= 1'b0;
            id_ex_valid_reg  <= 1'b0;
            ex_mem_valid_reg <= 1'b0;
            retired_reg      <= '0;
        end else begin
            // Counts on the pre-edge EX/MEM valid, independent of state.
            if (ex_mem_valid_reg)
                retired_reg <= retired_reg + CNT_ONE;

            case (state_reg)
                ST_RUN: begin
                    if (overflow_error_warning) begin
                        state_reg        <= ST_ERROR;
                        if_id_valid_reg  <= 1'b0;
                        id_ex_valid_reg  <= 1'b0;
                        ex_mem_valid_reg <= 1'b0;
                    end else if (halt) begin
                        // Let the instruction already in ID/EX drain into EX/MEM.
                        state_reg        <= ST_HALTED;
                        if_id_valid_reg  <= 1'b0;
                        id_ex_valid_reg  <= 1'b0;
                        ex_mem_valid_reg <= id_ex_valid_reg & ~ex_flush;
                    end else begin
                        if (pc_op)
                            pc_reg <= b_jmp ? branch_target : jump_target;
                        else if (!stall)
                            pc_reg <= pc_reg + PC_INC;

                        if_id_valid_reg  <= ~if_flush &
                                            ((stall & ~pc_op) ? if_id_valid_reg : 1'b1);
                        id_ex_valid_reg  <= if_id_valid_reg & ~id_flush & ~stall;
                        ex_mem_valid_reg <= id_ex_valid_reg & ~ex_flush;
                    end
                end

                ST_HALTED: begin
                    if_id_valid_reg  <= 1'b0;
                    id_ex_valid_reg  <= 1'b0;
                    ex_mem_valid_reg <= 1'b0;
                    if (overflow_error_warning)
                        state_reg <= ST_ERROR;
                end

                default: begin
                    // ERROR, and the unused encoding which is treated as ERROR.
                    state_reg        <= ST_ERROR;
                    if_id_valid_reg  <= 1'b0;
                    id_ex_valid_reg  <= 1'b0;
                    ex_mem_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_reg;
    assign if_id_valid  = if_id_valid_reg;
    assign id_ex_valid  = id_ex_valid_reg;
    assign ex_mem_valid = ex_mem_valid_reg;
    assign state        = state_reg;
    assign retired      = retired_reg;

endmodule
